// File: rtl/fan_mode_controller.sv
// PWM fan-motor sequencer: speed level FSM, soft duty ramp, auto-off timer
// and an internal PWM counter/comparator driving the motor pin.
module fan_mode_controller #(
  parameter int PWM_BITS         = 10,
  parameter int RAMP_TICK_CYCLES = 100000,
  parameter int STEP             = 8,
  parameter int SEC_CYCLES       = 100000000,
  parameter int TIMER_SEC        = 60
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_btn_speed,
  input  logic                i_btn_timer,
  input  logic                i_btn_off,
  output logic [2:0]          o_level,
  output logic [PWM_BITS-1:0] o_duty,
  output logic                o_pwm,
  output logic                o_ramping,
  output logic                o_timer_active,
  output logic [7:0]          o_timer_remain
);

  localparam int DUTY_MAX = (2 ** PWM_BITS) - 1;
  localparam int QUARTER  = 2 ** (PWM_BITS - 2);
  localparam int STEP_C   = (STEP > DUTY_MAX) ? DUTY_MAX : STEP;
  localparam int RAMP_W   = (RAMP_TICK_CYCLES > 1) ? $clog2(RAMP_TICK_CYCLES) : 1;
  localparam int SEC_W    = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;

  localparam logic [RAMP_W-1:0]   RAMP_LAST = RAMP_W'(RAMP_TICK_CYCLES - 1);
  localparam logic [RAMP_W-1:0]   RAMP_ONE  = RAMP_W'(1);
  localparam logic [SEC_W-1:0]    SEC_LAST  = SEC_W'(SEC_CYCLES - 1);
  localparam logic [SEC_W-1:0]    SEC_ONE   = SEC_W'(1);
  localparam logic [PWM_BITS-1:0] CNT_LAST  = '1;
  localparam logic [PWM_BITS-1:0] CNT_ONE   = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] STEP_V    = PWM_BITS'(STEP_C);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  // Target duty is a quarter of full scale per level, clamped to the counter maximum.
  function automatic logic [PWM_BITS-1:0] levelTarget(input logic [2:0] lvl);
    int v;
    v = int'(lvl) * QUARTER;
    if (v > DUTY_MAX) v = DUTY_MAX;
    return PWM_BITS'(v);
  endfunction

  function automatic logic [7:0] presetSeconds(input logic [1:0] preset);
    int v;
    v = int'(preset) * TIMER_SEC;
    if (v > 255) v = 255;
    return 8'(v);
  endfunction

  state_t              r_state;
  logic [2:0]          r_level;
  logic [PWM_BITS-1:0] r_target;
  logic [PWM_BITS-1:0] r_duty;
  logic [PWM_BITS-1:0] r_shadow;
  logic [PWM_BITS-1:0] r_pwmCnt;
  logic                r_pwm;
  logic [RAMP_W-1:0]   r_rampCnt;
  logic                r_timerActive;
  logic [1:0]          r_preset;
  logic [7:0]          r_remain;
  logic [SEC_W-1:0]    r_secCnt;

  logic                w_secTick;
  logic                w_expire;
  logic                w_speed;
  logic                w_timer;
  logic                w_rampTick;
  logic [PWM_BITS-1:0] w_diffUp;
  logic [PWM_BITS-1:0] w_diffDn;
  logic [1:0]          w_nextPreset;

  // Priority: off > expiry > speed > timer; losers in the same cycle are dropped.
  assign w_secTick    = r_timerActive && (r_secCnt == SEC_LAST);
  assign w_expire     = w_secTick && (r_remain == 8'd1);
  assign w_speed      = i_btn_speed && !i_btn_off && !w_expire;
  assign w_timer      = i_btn_timer && !i_btn_speed && !i_btn_off && !w_expire
                        && (r_state == S_RUN);
  assign w_rampTick   = (r_rampCnt == RAMP_LAST);
  assign w_diffUp     = r_target - r_duty;
  assign w_diffDn     = r_duty - r_target;
  assign w_nextPreset = r_preset + 2'd1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_level  <= 3'd0;
      r_target <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_speed) begin
            r_state  <= S_RUN;
            r_level  <= 3'd1;
            r_target <= levelTarget(3'd1);
          end
        end
        S_RUN: begin
          if (i_btn_off || w_expire) begin
            r_state  <= S_IDLE;
            r_level  <= 3'd0;
            r_target <= '0;
          end else if (w_speed) begin
            if (r_level >= 3'd4) begin
              r_level  <= 3'd1;
              r_target <= levelTarget(3'd1);
            end else begin
              r_level  <= r_level + 3'd1;
              r_target <= levelTarget(r_level + 3'd1);
            end
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_level  <= 3'd0;
          r_target <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_timerActive <= 1'b0;
      r_preset      <= 2'd0;
      r_remain      <= 8'd0;
      r_secCnt      <= '0;
    end else if (i_btn_off || w_expire) begin
      r_timerActive <= 1'b0;
      r_preset      <= 2'd0;
      r_remain      <= 8'd0;
      r_secCnt      <= '0;
    end else if (w_timer) begin
      r_secCnt <= '0;
      if (r_preset == 2'd3) begin
        r_timerActive <= 1'b0;
        r_preset      <= 2'd0;
        r_remain      <= 8'd0;
      end else begin
        r_timerActive <= 1'b1;
        r_preset      <= w_nextPreset;
        r_remain      <= presetSeconds(w_nextPreset);
      end
    end else if (r_timerActive) begin
      r_secCnt <= w_secTick ? '0 : (r_secCnt + SEC_ONE);
      if (w_secTick && (r_remain != 8'd0)) r_remain <= r_remain - 8'd1;
    end
  end

  // Duty walks toward whatever the target is at the tick, never past it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rampCnt <= '0;
      r_duty    <= '0;
    end else begin
      r_rampCnt <= w_rampTick ? '0 : (r_rampCnt + RAMP_ONE);
      if (w_rampTick) begin
        if (r_duty < r_target) begin
          r_duty <= (w_diffUp > STEP_V) ? (r_duty + STEP_V) : r_target;
        end else if (r_duty > r_target) begin
          r_duty <= (w_diffDn > STEP_V) ? (r_duty - STEP_V) : r_target;
        end
      end
    end
  end

  // Shadow only reloads at the period boundary so a duty change never splits a pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pwmCnt <= '0;
      r_shadow <= '0;
      r_pwm    <= 1'b0;
    end else begin
      r_pwmCnt <= r_pwmCnt + CNT_ONE;
      if (r_pwmCnt == CNT_LAST) r_shadow <= r_duty;
      r_pwm <= (r_pwmCnt < r_shadow);
    end
  end

  assign o_level        = r_level;
  assign o_duty         = r_duty;
  assign o_pwm          = r_pwm;
  assign o_ramping      = (r_duty != r_target);
  assign o_timer_active = r_timerActive;
  assign o_timer_remain = r_remain;

endmodule

// File: tb/tb_fan_mode_controller.sv
// Scoreboard bench for fan_mode_controller: a cycle model pushes expected outputs
// per driven cycle, popped after the edge; directed checks cover the key scenarios.
module tb_fan_mode_controller;

  localparam int PWM_BITS = 10;
  localparam int RAMP     = 4;
  localparam int STEPV    = 64;
  localparam int SECC     = 16;
  localparam int TSEC     = 3;
  localparam int CMAX     = (2 ** PWM_BITS) - 1;

  logic                i_clk = 1'b0;
  logic                i_reset = 1'b0;
  logic                i_btn_speed = 1'b0;
  logic                i_btn_timer = 1'b0;
  logic                i_btn_off = 1'b0;
  logic [2:0]          o_level;
  logic [PWM_BITS-1:0] o_duty;
  logic                o_pwm;
  logic                o_ramping;
  logic                o_timer_active;
  logic [7:0]          o_timer_remain;

  fan_mode_controller #(
    .PWM_BITS(PWM_BITS),
    .RAMP_TICK_CYCLES(RAMP),
    .STEP(STEPV),
    .SEC_CYCLES(SECC),
    .TIMER_SEC(TSEC)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_btn_speed(i_btn_speed),
    .i_btn_timer(i_btn_timer),
    .i_btn_off(i_btn_off),
    .o_level(o_level),
    .o_duty(o_duty),
    .o_pwm(o_pwm),
    .o_ramping(o_ramping),
    .o_timer_active(o_timer_active),
    .o_timer_remain(o_timer_remain)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int level;
    int duty;
    int pwm;
    int ramping;
    int active;
    int remain;
  } exp_t;

  exp_t sbQ[$];
  int checks = 0;
  int errors = 0;

  int mLevel = 0, mTarget = 0, mDuty = 0, mShadow = 0, mCnt = 0, mPwm = 0;
  int mActive = 0, mPreset = 0, mRemain = 0, mSec = 0, mRamp = 0;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference behaviour: next state computed entirely from the current state.
  task automatic modelStep(input bit rst, input bit spd, input bit tmr, input bit off);
    int nLevel, nDuty, nShadow, nCnt, nPwm, nActive, nPreset, nRemain, nSec, nRamp;
    bit secTick, expire;
    if (rst) begin
      mLevel = 0; mTarget = 0; mDuty = 0; mShadow = 0; mCnt = 0; mPwm = 0;
      mActive = 0; mPreset = 0; mRemain = 0; mSec = 0; mRamp = 0;
    end else begin
      secTick = (mActive != 0) && (mSec == SECC - 1);
      expire  = secTick && (mRemain == 1);
      nDuty = mDuty;
      if (mRamp == RAMP - 1) begin
        if (mTarget > mDuty) nDuty = (mTarget - mDuty > STEPV) ? mDuty + STEPV : mTarget;
        else if (mTarget < mDuty) nDuty = (mDuty - mTarget > STEPV) ? mDuty - STEPV : mTarget;
      end
      nRamp   = (mRamp == RAMP - 1) ? 0 : mRamp + 1;
      nShadow = (mCnt == CMAX) ? mDuty : mShadow;
      nPwm    = (mCnt < mShadow) ? 1 : 0;
      nCnt    = (mCnt + 1) % (CMAX + 1);
      nLevel  = mLevel;
      nActive = mActive;
      nPreset = mPreset;
      nRemain = mRemain;
      nSec    = mActive ? (secTick ? 0 : mSec + 1) : mSec;
      if (secTick && mRemain > 0) nRemain = mRemain - 1;
      if (off || expire) begin
        nLevel = 0; nActive = 0; nPreset = 0; nRemain = 0; nSec = 0;
      end else if (spd) begin
        nLevel = (mLevel == 4) ? 1 : mLevel + 1;
      end else if (tmr && mLevel != 0) begin
        nPreset = (mPreset + 1) % 4;
        nSec = 0;
        if (nPreset == 0) begin
          nActive = 0; nRemain = 0;
        end else begin
          nActive = 1;
          nRemain = (nPreset * TSEC > 255) ? 255 : nPreset * TSEC;
        end
      end
      mLevel = nLevel;
      mTarget = (nLevel * 256 > CMAX) ? CMAX : nLevel * 256;
      mDuty = nDuty; mShadow = nShadow; mCnt = nCnt; mPwm = nPwm;
      mActive = nActive; mPreset = nPreset; mRemain = nRemain; mSec = nSec; mRamp = nRamp;
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit spd, input bit tmr, input bit off);
    exp_t e;
    i_reset = rst; i_btn_speed = spd; i_btn_timer = tmr; i_btn_off = off;
    modelStep(rst, spd, tmr, off);
    e.level = mLevel; e.duty = mDuty; e.pwm = mPwm;
    e.ramping = (mDuty != mTarget) ? 1 : 0;
    e.active = mActive; e.remain = mRemain;
    sbQ.push_back(e);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0; i_btn_speed = 1'b0; i_btn_timer = 1'b0; i_btn_off = 1'b0;
    if (sbQ.size() == 0) begin
      checkOutput("sbEmpty", 0, 1);
    end else begin
      e = sbQ.pop_front();
      checkOutput("sb.level", int'(o_level), e.level);
      checkOutput("sb.duty", int'(o_duty), e.duty);
      checkOutput("sb.pwm", int'(o_pwm), e.pwm);
      checkOutput("sb.ramping", int'(o_ramping), e.ramping);
      checkOutput("sb.active", int'(o_timer_active), e.active);
      checkOutput("sb.remain", int'(o_timer_remain), e.remain);
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0);
  endtask

  task automatic countPwmHigh(input int n, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 0, 0, 0);
      highs += int'(o_pwm);
    end
  endtask

  initial begin
    int highs;
    bit hit;

    // Reset state
    applyStimulus(1, 0, 0, 0);
    checkOutput("rst.level", int'(o_level), 0);
    checkOutput("rst.duty", int'(o_duty), 0);
    checkOutput("rst.pwm", int'(o_pwm), 0);
    checkOutput("rst.active", int'(o_timer_active), 0);
    checkOutput("rst.remain", int'(o_timer_remain), 0);

    // Level 1 ramp 64..256 and PWM high count
    applyStimulus(0, 1, 0, 0);
    checkOutput("l1.level", int'(o_level), 1);
    for (int i = 1; i <= 4; i++) begin
      runCycles(4);
      checkOutput("l1.duty", int'(o_duty), 64 * i);
    end
    checkOutput("l1.ramping", int'(o_ramping), 0);
    runCycles(1100);
    countPwmHigh(1024, highs);
    checkOutput("l1.pwmHigh", highs, 256);

    // Five presses: 1,2,3,4 then wrap to 1; level 4 settles at 1023
    applyStimulus(1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 1, 0, 0);
      checkOutput("wrap.level", int'(o_level), i);
    end
    runCycles(80);
    checkOutput("l4.duty", int'(o_duty), 1023);
    checkOutput("l4.ramping", int'(o_ramping), 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("wrap.level1", int'(o_level), 1);

    // Level 2 at 512, then off ramps down to 0 and PWM stays low
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    runCycles(40);
    checkOutput("l2.duty", int'(o_duty), 512);
    applyStimulus(0, 0, 0, 1);
    checkOutput("off.level", int'(o_level), 0);
    runCycles(4);
    checkOutput("off.duty448", int'(o_duty), 448);
    runCycles(40);
    checkOutput("off.duty0", int'(o_duty), 0);
    runCycles(1100);
    countPwmHigh(1024, highs);
    checkOutput("off.pwmHigh", highs, 0);

    // Timer arm, countdown, expiry swallowing a same-cycle speed press
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("tmr.active", int'(o_timer_active), 1);
    checkOutput("tmr.remain3", int'(o_timer_remain), 3);
    runCycles(16);
    checkOutput("tmr.remain2", int'(o_timer_remain), 2);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (mActive != 0 && mSec == SECC - 1 && mRemain == 1) begin
        applyStimulus(0, 1, 0, 0);
        hit = 1;
      end else begin
        applyStimulus(0, 0, 0, 0);
      end
    end
    checkOutput("exp.reached", int'(hit), 1);
    checkOutput("exp.level", int'(o_level), 0);
    checkOutput("exp.active", int'(o_timer_active), 0);

    // Preset cycling 3,6,9,off; timer press in idle ignored
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 0, 1, 0);
      checkOutput("preset.remain", int'(o_timer_remain), 3 * i);
    end
    applyStimulus(0, 0, 1, 0);
    checkOutput("preset.off", int'(o_timer_active), 0);
    checkOutput("preset.remain0", int'(o_timer_remain), 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 1, 0);
    checkOutput("idle.tmrActive", int'(o_timer_active), 0);
    checkOutput("idle.level", int'(o_level), 0);

    // Reset mid-ramp at duty 320 with timer active
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      applyStimulus(0, 0, 0, 0);
      if (int'(o_duty) == 320) hit = 1;
    end
    checkOutput("mid.reached320", int'(hit), 1);
    checkOutput("mid.active", int'(o_timer_active), 1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("mid.level", int'(o_level), 0);
    checkOutput("mid.duty", int'(o_duty), 0);
    checkOutput("mid.pwm", int'(o_pwm), 0);
    checkOutput("mid.ramping", int'(o_ramping), 0);
    checkOutput("mid.active0", int'(o_timer_active), 0);
    checkOutput("mid.remain", int'(o_timer_remain), 0);

    // Speed and off together: off wins
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 1);
    checkOutput("both.level", int'(o_level), 0);
    runCycles(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fan_mode_controller.md
Name: fan_mode_controller

Overview:
Sequencer for the PWM fan-motor datapath. It takes debounced one-cycle button pulses and maintains a speed level from 0 to 4. It soft-ramps the PWM duty toward that level's target and runs an auto-off countdown timer. It owns its own PWM counter and comparator, drives the motor pin directly, and exposes level and timer status for the LED and FND display blocks.

Parameters:
PWM_BITS, 10, width of the PWM counter and duty values; period is 2^PWM_BITS cycles
RAMP_TICK_CYCLES, 100000, clock cycles between duty ramp steps
STEP, 8, maximum duty change per ramp step
SEC_CYCLES, 100000000, clock cycles per timer second
TIMER_SEC, 60, seconds added per timer preset step

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_btn_speed  in  1  one-cycle pulse: advance speed level
i_btn_timer  in  1  one-cycle pulse: cycle the off-timer preset
i_btn_off  in  1  one-cycle pulse: stop the fan
o_level  out  3  current speed level, 0 to 4
o_duty  out  PWM_BITS  current ramped duty
o_pwm  out  1  motor PWM output
o_ramping  out  1  high while o_duty differs from the target duty
o_timer_active  out  1  off-timer armed
o_timer_remain  out  8  seconds remaining on the off-timer

Behaviour:
- Reset, sampled on the i_clk edge while i_reset=1: level=0, duty=0, target=0, shadow duty=0, PWM counter=0, o_pwm=0, timer inactive, remain=0, all prescalers=0. Reset mid-ramp or mid-timer aborts immediately.
- Target duty per level = min(level*2^(PWM_BITS-2), 2^PWM_BITS-1). With PWM_BITS=10: 0, 256, 512, 768, 1023.
- FSM states:
  - S_IDLE: level=0.
  - S_RUN: level 1 to 4.
  - S_IDLE to S_RUN on a speed press; level becomes 1.
  - In S_RUN, a speed press advances level 1->2->3->4->1 (wrap).
  - S_RUN to S_IDLE on an off press or on timer expiry; level becomes 0 and the timer is cleared.
- Event priority within one cycle: reset > off press > timer expiry > speed press > timer press. Lower-priority events in the same cycle are discarded, not queued.
- Level, target and timer registers update one cycle after the pulse. o_level reflects the new value on the next edge.
- Timer press:
  - Ignored in S_IDLE.
  - In S_RUN, the preset cycles off -> TIMER_SEC -> 2*TIMER_SEC -> 3*TIMER_SEC -> off.
  - Any arming or preset change reloads remain and clears the seconds prescaler.
  - Presets above 255 saturate to 255.
- Seconds prescaler runs only while the timer is active and ticks when it reaches SEC_CYCLES-1.
  - Each tick decrements remain.
  - A tick with remain=1 sets remain=0 and fires expiry in that cycle.
- Ramp prescaler is free-running from 0 to RAMP_TICK_CYCLES-1. On each wrap, duty moves toward target by min(STEP, |target-duty|), with no overshoot or underflow.
- o_ramping = (duty != target), combinational from registers.
- Target changes mid-ramp take effect at the next ramp tick from the current duty; the ramp is not restarted.
- PWM:
  - The counter wraps at 2^PWM_BITS-1.
  - The shadow duty loads o_duty only in the cycle the counter equals 2^PWM_BITS-1, so it is glitch-free.
  - o_pwm is registered: 1 when counter < shadow.
  - Duty 0 gives constant 0. Duty 1023 gives 1023/1024 high.

Test Plan:
(Bench parameters: PWM_BITS=10, RAMP_TICK_CYCLES=4, STEP=64, SEC_CYCLES=16, TIMER_SEC=3.)
- Reset then one i_btn_speed pulse -> o_level=1 next cycle; o_duty steps 64, 128, 192, 256 on 4 successive ramp ticks (16 cycles); o_ramping falls when o_duty=256; o_pwm high for counts 0 to 255 of the following period.
- Five speed pulses from reset -> o_level sequence 1, 2, 3, 4, 1; at level 4, o_duty settles at 1023 (last step +63, no overshoot).
- Level 2 with o_duty=512, then i_btn_off -> o_level=0, o_duty falls 448 ... 0; o_pwm stays 0 after the first PWM period that latches shadow 0.
- Level 1, one timer pulse -> o_timer_active=1, o_timer_remain=3, decrementing every 16 cycles; at expiry o_level=0 and o_timer_active=0, and a speed pulse in the expiry cycle is ignored.
- Four timer pulses in S_RUN -> remain 3, 6, 9, then inactive; a timer pulse in S_IDLE -> no change.
- Assert i_reset for one cycle mid-ramp with o_duty=320 and the timer active -> all outputs 0 on the next edge; simultaneous speed and off pulses -> o_level=0.
